sine_lut_pipe: RTL and testbench

SINE_LUT_PIPE -- requirements
Module: sine_lut_pipe

---
 rtl/sine_pkg.sv | 41 ++++
 rtl/sine_quarter_rom.sv | 102 ++++++++++
 rtl/sine_lut_pipe.sv | 98 +++++++++
 tb/tb_sine_lut_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared constants and quadrant helpers for the sine lookup pipeline.
// Both channels classify their phase through the same quadrant functions.
package sine_pkg;

    localparam int SINE_AW = 8;
    localparam int SINE_DW = 8;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    function automatic int mid_for(input int dw);
        return 32'sd1 << (dw - 32'sd1);
    endfunction

    localparam int MID = mid_for(SINE_DW);

    // Quadrants 1 and 3 walk the quarter-wave table backwards.
    function automatic logic quad_mirrored(input quadrant_e q);
        logic m;
        case (q)
            Q1, Q3:  m = 1'b1;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Quadrants 2 and 3 sit below mid-scale.
    function automatic logic quad_negative(input quadrant_e q);
        logic n;
        case (q)
            Q2, Q3:  n = 1'b1;
            default: n = 1'b0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave sine magnitude table, round(127*sin(2*pi*(i+0.5)/256)).
// Exact for AW=8/DW=8; other sizes resample the 64-entry base table and rescale it.
module sine_quarter_rom #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic [AW-3:0] idx,
    output logic [DW-2:0] mag
);

    logic [5:0] idx6_s;
    logic [6:0] base_s;

    if (AW == 8) begin : g_idx_eq
        assign idx6_s = idx;
    end else if (AW > 8) begin : g_idx_wide
        assign idx6_s = idx[AW-3 -: 6];
    end else begin : g_idx_narrow
        assign idx6_s = {idx, {(8-AW){1'b0}}};
    end

    if (DW == 8) begin : g_dw_eq
        assign mag = base_s;
    end else if (DW > 8) begin : g_dw_wide
        assign mag = {base_s, {(DW-8){1'b0}}};
    end else begin : g_dw_narrow
        assign mag = base_s[6 -: (DW-1)];
    end

    // Base quarter-wave magnitude table.
    always_comb begin
        base_s = 7'd0;
        case (idx6_s)
            6'd0:    base_s = 7'd2;
            6'd1:    base_s = 7'd5;
            6'd2:    base_s = 7'd8;
            6'd3:    base_s = 7'd11;
            6'd4:    base_s = 7'd14;
            6'd5:    base_s = 7'd17;
            6'd6:    base_s = 7'd20;
            6'd7:    base_s = 7'd23;
            6'd8:    base_s = 7'd26;
            6'd9:    base_s = 7'd29;
            6'd10:   base_s = 7'd32;
            6'd11:   base_s = 7'd35;
            6'd12:   base_s = 7'd38;
            6'd13:   base_s = 7'd41;
            6'd14:   base_s = 7'd44;
            6'd15:   base_s = 7'd47;
            6'd16:   base_s = 7'd50;
            6'd17:   base_s = 7'd53;
            6'd18:   base_s = 7'd56;
            6'd19:   base_s = 7'd58;
            6'd20:   base_s = 7'd61;
            6'd21:   base_s = 7'd64;
            6'd22:   base_s = 7'd67;
            6'd23:   base_s = 7'd69;
            6'd24:   base_s = 7'd72;
            6'd25:   base_s = 7'd74;
            6'd26:   base_s = 7'd77;
            6'd27:   base_s = 7'd79;
            6'd28:   base_s = 7'd82;
            6'd29:   base_s = 7'd84;
            6'd30:   base_s = 7'd86;
            6'd31:   base_s = 7'd89;
            6'd32:   base_s = 7'd91;
            6'd33:   base_s = 7'd93;
            6'd34:   base_s = 7'd95;
            6'd35:   base_s = 7'd97;
            6'd36:   base_s = 7'd99;
            6'd37:   base_s = 7'd101;
            6'd38:   base_s = 7'd103;
            6'd39:   base_s = 7'd105;
            6'd40:   base_s = 7'd106;
            6'd41:   base_s = 7'd108;
            6'd42:   base_s = 7'd110;
            6'd43:   base_s = 7'd111;
            6'd44:   base_s = 7'd113;
            6'd45:   base_s = 7'd114;
            6'd46:   base_s = 7'd115;
            6'd47:   base_s = 7'd117;
            6'd48:   base_s = 7'd118;
            6'd49:   base_s = 7'd119;
            6'd50:   base_s = 7'd120;
            6'd51:   base_s = 7'd121;
            6'd52:   base_s = 7'd122;
            6'd53:   base_s = 7'd123;
            6'd54:   base_s = 7'd124;
            6'd55:   base_s = 7'd124;
            6'd56:   base_s = 7'd125;
            6'd57:   base_s = 7'd125;
            6'd58:   base_s = 7'd126;
            6'd59:   base_s = 7'd126;
            6'd60:   base_s = 7'd127;
            6'd61:   base_s = 7'd127;
            6'd62:   base_s = 7'd127;
            6'd63:   base_s = 7'd127;
            default: base_s = 7'd0;
        endcase
    end

endmodule

// File: rtl/sine_lut_pipe.sv
// Two-channel sine lookup: channel 1 at phase addr, channel 2 at addr+offset.
// Stage 1 holds table magnitude and sign, stage 2 holds the mid-scale-applied sample.
module sine_lut_pipe
    import sine_pkg::*;
#(
    parameter int AW = SINE_AW,
    parameter int DW = SINE_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] offset,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2,
    output logic          vld
);

    localparam logic [DW-1:0] MID_V = (DW == SINE_DW) ? DW'(MID) : DW'(mid_for(DW));

    logic [AW-1:0] phase_s  [2];
    logic [AW-3:0] idx_s    [2];
    logic          mirror_s [2];
    logic          neg_s    [2];
    logic [DW-2:0] rom_s    [2];

    logic          vld1_q;
    logic          vld2_q;
    logic [DW-2:0] mag_q    [2];
    logic          neg_q    [2];
    logic [DW-1:0] samp_q   [2];
    logic [DW-1:0] samp_d   [2];

    assign phase_s[0] = addr;
    assign phase_s[1] = addr + offset;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        quadrant_e     q_s;
        logic [AW-3:0] low_s;

        assign q_s          = quadrant_e'(phase_s[ch][AW-1 -: 2]);
        assign low_s        = phase_s[ch][AW-3:0];
        assign mirror_s[ch] = quad_mirrored(q_s);
        assign neg_s[ch]    = quad_negative(q_s);
        // Bitwise inversion of low is (N-1)-low.
        assign idx_s[ch]    = mirror_s[ch] ? ~low_s : low_s;

        sine_quarter_rom #(
            .AW (AW),
            .DW (DW)
        ) u_rom (
            .idx (idx_s[ch]),
            .mag (rom_s[ch])
        );
    end

    // Apply the stored sign around mid-scale; magnitude never exceeds mid-1.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            samp_d[ch] = MID_V;
            if (neg_q[ch]) begin
                samp_d[ch] = MID_V - {1'b0, mag_q[ch]};
            end else begin
                samp_d[ch] = MID_V + {1'b0, mag_q[ch]};
            end
        end
    end

    // Pipeline state; a zero magnitude register represents the mid-scale sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                mag_q[ch]  <= {(DW-1){1'b0}};
                neg_q[ch]  <= 1'b0;
                samp_q[ch] <= MID_V;
            end
        end else begin
            vld1_q <= en;
            vld2_q <= vld1_q;
            for (int ch = 0; ch < 2; ch++) begin
                if (en) begin
                    mag_q[ch] <= rom_s[ch];
                    neg_q[ch] <= neg_s[ch];
                end
                if (vld1_q) begin
                    samp_q[ch] <= samp_d[ch];
                end
            end
        end
    end

    assign dout1 = samp_q[0];
    assign dout2 = samp_q[1];
    assign vld   = vld2_q;

endmodule

// File: tb/tb_sine_lut_pipe.sv
// Directed bench for sine_lut_pipe: hand-computed vectors, full phase sweep,
// bubble handling and reset in flight, with an independent $sin-based model.
module tb_sine_lut_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] addr;
    logic [7:0] offset;
    logic [7:0] dout1;
    logic [7:0] dout2;
    logic       vld;

    int checks;
    int failures;
    int tbl [64];
    int d1s [256];
    int pulses;

    localparam int NV  = 7;
    localparam int OFF = 37;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] offset;
        int         exp1;
        int         exp2;
    } vec_t;

    vec_t vecs [NV];

    sine_lut_pipe #(
        .AW (8),
        .DW (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .addr   (addr),
        .offset (offset),
        .dout1  (dout1),
        .dout2  (dout2),
        .vld    (vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gold(input int ph);
        int p;
        int q;
        int low;
        int idx;
        p   = ph & 255;
        q   = p >> 6;
        low = p & 63;
        idx = (q == 1 || q == 3) ? 63 - low : low;
        return (q < 2) ? 128 + tbl[idx] : 128 - tbl[idx];
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        pulses   = 0;
        for (int i = 0; i < 64; i++) begin
            tbl[i] = $rtoi(127.0 * $sin(2.0 * 3.14159265358979 * (i + 0.5) / 256.0) + 0.5);
        end

        vecs[0] = '{addr: 8'd0,   offset: 8'd64,  exp1: 130, exp2: 255};
        vecs[1] = '{addr: 8'd128, offset: 8'd64,  exp1: 126, exp2: 1};
        vecs[2] = '{addr: 8'd255, offset: 8'd1,   exp1: 126, exp2: 130};
        vecs[3] = '{addr: 8'd64,  offset: 8'd0,   exp1: 255, exp2: 255};
        vecs[4] = '{addr: 8'd192, offset: 8'd32,  exp1: 1,   exp2: 39};
        vecs[5] = '{addr: 8'd32,  offset: 8'd0,   exp1: 219, exp2: 219};
        vecs[6] = '{addr: 8'd100, offset: 8'd200, exp1: 207, exp2: 241};

        rst    = 1'b1;
        en     = 1'b0;
        addr   = 8'd0;
        offset = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_vld",   int'(vld),   0);
        check("reset_dout1", int'(dout1), 128);
        check("reset_dout2", int'(dout2), 128);
        rst = 1'b0;

        // Hand vectors streamed back to back, observed two edges later.
        for (int c = 0; c < NV + 2; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check($sformatf("vec%0d_vld", c - 2),   int'(vld),   1);
                check($sformatf("vec%0d_dout1", c - 2), int'(dout1), vecs[c-2].exp1);
                check($sformatf("vec%0d_dout2", c - 2), int'(dout2), vecs[c-2].exp2);
            end
            if (c < NV) begin
                en     = 1'b1;
                addr   = vecs[c].addr;
                offset = vecs[c].offset;
            end else begin
                en = 1'b0;
            end
        end

        // Full phase sweep at one sample per cycle.
        for (int c = 0; c < 258; c++) begin
            @(negedge clk);
            if (vld) pulses++;
            if (c >= 2) begin
                check($sformatf("sweep%0d_vld", c - 2),   int'(vld),   1);
                check($sformatf("sweep%0d_dout1", c - 2), int'(dout1), gold(c - 2));
                check($sformatf("sweep%0d_dout2", c - 2), int'(dout2), gold(c - 2 + OFF));
                d1s[c-2] = int'(dout1);
            end
            if (c < 256) begin
                en     = 1'b1;
                addr   = 8'(c);
                offset = 8'(OFF);
            end else begin
                en = 1'b0;
            end
        end
        @(negedge clk);
        if (vld) pulses++;
        check("sweep_pulses", pulses, 256);
        for (int k = 0; k < 128; k++) begin
            check($sformatf("sym%0d", k), d1s[k] + d1s[k+128], 256);
        end

        // Bubble: en 1,0,1 gives vld 1,0,1 two edges later, outputs held in the gap.
        en = 1'b1; addr = 8'd10; offset = 8'd0;
        @(negedge clk);
        en = 1'b0; addr = 8'd99; offset = 8'd5;
        @(negedge clk);
        en = 1'b1; addr = 8'd20; offset = 8'd0;
        check("bub0_vld",   int'(vld),   1);
        check("bub0_dout1", int'(dout1), gold(10));
        @(negedge clk);
        en = 1'b0;
        check("bub1_vld",   int'(vld),   0);
        check("bub1_hold1", int'(dout1), gold(10));
        check("bub1_hold2", int'(dout2), gold(10));
        @(negedge clk);
        check("bub2_vld",   int'(vld),   1);
        check("bub2_dout1", int'(dout1), gold(20));
        @(negedge clk);
        check("bub3_vld",   int'(vld),   0);
        check("bub3_hold1", int'(dout1), gold(20));

        // Reset one cycle after en=1: no pulse, immediate mid outputs.
        en = 1'b1; addr = 8'd0; offset = 8'd64;
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_vld",   int'(vld),   0);
        check("rst_async_dout1", int'(dout1), 128);
        check("rst_async_dout2", int'(dout2), 128);
        @(negedge clk);
        check("rst_hold_vld", int'(vld), 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_post%0d_vld", c),   int'(vld),   0);
            check($sformatf("rst_post%0d_dout1", c), int'(dout1), 128);
        end
        en = 1'b1; addr = 8'd128; offset = 8'd64;
        @(negedge clk);
        en = 1'b0;
        check("rst_first_e1_vld", int'(vld), 0);
        @(negedge clk);
        check("rst_first_vld",   int'(vld),   1);
        check("rst_first_dout1", int'(dout1), 126);
        check("rst_first_dout2", int'(dout2), 1);
        @(negedge clk);
        check("rst_first_end_vld", int'(vld), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
